// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// alu_muldiv_seq
// ----------------------------------------------------------------------------
// Sequential 16x16 unsigned multiplier / 16/16 unsigned divider. It does no
// arithmetic of its own. Every add or subtract is done by an external
// combinational ALU that this block drives through its alu_* port group.
//
// Multiply uses shift-and-add over 16 steps. Divide uses restoring-style
// shift-and-subtract over 16 steps. A divide with a zero divisor
// short-circuits to DONE with saturated results.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start, cmd          : command request; cmd 0 = multiply, 1 = divide
//   opa, opb            : operands, captured when start is accepted
//   busy                : high while an operation is running
//   done                : one-cycle completion pulse
//   result_hi/lo        : mul -> product high/low; div -> remainder/quotient
//   div_by_zero         : flags a divide whose divisor was zero
//   alu_a, alu_b, alu_op: operands and operation select sent to the ALU
//   alu_sh_off          : tied to 4'h0
//   alu_truth_table     : tied to 4'h0
//   alu_out, alu_carry  : combinational result and carry-out from the ALU
//
// Timing
//   start accepted at edge N. Normal op: done is high in the cycle after
//   edge N+17. Divide by zero: done is high in the cycle after edge N+1.
//   The first RUN cycle is a prime cycle. It checks for a zero divisor and
//   lets the freshly loaded accumulators reach the ALU. The 16 arithmetic
//   steps follow it.
// ============================================================================
module alu_muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cmd,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result_hi,
    output logic [15:0] result_lo,
    output logic        div_by_zero,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_sh_off,
    output logic [3:0]  alu_truth_table,
    output logic [4:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_carry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00001;
    localparam logic [4:0] ALU_SUB = 5'b00111;  // carry = no-borrow

    // Shared datapath registers:
    //   multiply: hi_q = ACC_HI, lo_q = ACC_LO, opnd_q = M (multiplicand)
    //   divide  : hi_q = R,      lo_q = Q,      opnd_q = D (divisor)
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        prime_q, prime_d;
    logic        cmd_q, cmd_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] opnd_q, opnd_d;
    logic [15:0] res_hi_d, res_lo_d;
    logic        dbz_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge value of its neighbours. Blocking here would
    // create order-dependent races between the registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            prime_q     <= 1'b0;
            cmd_q       <= 1'b0;
            hi_q        <= 16'h0;
            lo_q        <= 16'h0;
            opnd_q      <= 16'h0;
            result_hi   <= 16'h0;
            result_lo   <= 16'h0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prime_q     <= prime_d;
            cmd_q       <= cmd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            result_hi   <= res_hi_d;
            result_lo   <= res_lo_d;
            div_by_zero <= dbz_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, datapath and ALU drive
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case.
        // Any path that skips an assignment then holds the register value
        // instead of inferring a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        prime_d  = prime_q;
        cmd_d    = cmd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        res_hi_d = result_hi;
        res_lo_d = result_lo;
        dbz_d    = div_by_zero;
        alu_a    = 16'h0;
        alu_b    = 16'h0;
        alu_op   = ALU_ADD;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Load the working registers straight from the operands.
                    // Multiply starts with ACC = {0, opb} and M = opa.
                    // Divide starts with R = 0, Q = opa and D = opb.
                    cmd_d   = cmd;
                    hi_d    = 16'h0;
                    lo_d    = cmd ? opa : opb;
                    opnd_d  = cmd ? opb : opa;
                    cnt_d   = 4'd0;
                    prime_d = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (cmd_q) begin
                    // Present {R,Q} shifted left by one. The 17th bit
                    // (R[15]) is tracked separately because it guarantees
                    // the subtract succeeds.
                    alu_a  = {hi_q[14:0], lo_q[15]};
                    alu_b  = opnd_q;
                    alu_op = ALU_SUB;
                end else begin
                    alu_a  = hi_q;
                    alu_b  = opnd_q;
                    alu_op = ALU_ADD;
                end

                if (prime_q) begin
                    prime_d = 1'b0;
                    if (cmd_q && (opnd_q == 16'h0)) begin
                        res_lo_d = 16'hFFFF;
                        res_hi_d = lo_q;        // still holds opa
                        dbz_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                end else begin
                    if (cmd_q) begin
                        if (hi_q[15] || alu_carry) begin
                            hi_d = alu_out;
                            lo_d = {lo_q[14:0], 1'b1};
                        end else begin
                            hi_d = {hi_q[14:0], lo_q[15]};
                            lo_d = {lo_q[14:0], 1'b0};
                        end
                    end else begin
                        // Add the multiplicand when the current multiplier
                        // LSB is set. Then shift the whole 33-bit
                        // {carry, ACC} right by one.
                        if (lo_q[0]) begin
                            {hi_d, lo_d} = {alu_carry, alu_out, lo_q[15:1]};
                        end else begin
                            {hi_d, lo_d} = {1'b0, hi_q, lo_q[15:1]};
                        end
                    end

                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        res_hi_d = hi_d;
                        res_lo_d = lo_d;
                        state_d  = S_DONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign alu_sh_off      = 4'h0;
    assign alu_truth_table = 4'h0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ============================================================================
// tb_alu_muldiv_seq
// ----------------------------------------------------------------------------
// Self-checking bench for alu_muldiv_seq. It supplies a behavioural ALU
// (add, and subtract with a no-borrow carry). Expected results come from
// plain '*', '/' and '%' on the operands.
// ============================================================================
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cmd;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        busy;
    logic        done;
    logic [15:0] result_hi;
    logic [15:0] result_lo;
    logic        div_by_zero;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sh_off;
    logic [3:0]  alu_truth_table;
    logic [4:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_carry;

    int checks;
    int errors;

    alu_muldiv_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cmd            (cmd),
        .opa            (opa),
        .opb            (opb),
        .busy           (busy),
        .done           (done),
        .result_hi      (result_hi),
        .result_lo      (result_lo),
        .div_by_zero    (div_by_zero),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_sh_off     (alu_sh_off),
        .alu_truth_table(alu_truth_table),
        .alu_op         (alu_op),
        .alu_out        (alu_out),
        .alu_carry      (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model
    always_comb begin
        alu_out   = 16'h0;
        alu_carry = 1'b0;
        case (alu_op)
            5'b00001: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            5'b00111: begin
                alu_out   = alu_a - alu_b;
                alu_carry = (alu_a >= alu_b);
            end
            default: ;
        endcase
    end

    // Reference model: {result_hi, result_lo, div_by_zero}
    function automatic logic [32:0] model(input logic c, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        if (!c) begin
            p = {16'h0, a} * {16'h0, b};
            return {p, 1'b0};
        end
        if (b == 16'h0) return {a, 16'hFFFF, 1'b1};
        return {a % b, a / b, 1'b0};
    endfunction

    // Counts edges after the current point until done is seen (-1 on timeout)
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic c, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] hi, output logic [15:0] lo,
                          output logic dz, output int lat);
        @(negedge clk);
        start = 1'b1; cmd = c; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        hi = result_hi; lo = result_lo; dz = div_by_zero;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, div_by_zero, result_hi, result_lo} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
                     busy, done, div_by_zero, result_hi, result_lo);
        end
        checks++;
        if ({alu_a, alu_b, alu_op, alu_sh_off, alu_truth_table} !== {32'h0, 5'b00001, 8'h0}) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h op=%b sh=%h tt=%h, want 0 0 00001 0 0",
                     alu_a, alu_b, alu_op, alu_sh_off, alu_truth_table);
        end
    endtask

    task automatic test_directed;
        logic [15:0] hi, lo;
        logic        dz;
        int          lat;
        logic [3:0]  c_l;
        logic [15:0] a_l [4];
        logic [15:0] b_l [4];
        logic [32:0] exp_l [4];
        c_l = 4'b1100;
        a_l = '{16'd3, 16'hFFFF, 16'd100, 16'hFFFF};
        b_l = '{16'd5, 16'hFFFF, 16'd7, 16'd1};
        exp_l = '{{32'h0000_000F, 1'b0}, {32'hFFFE_0001, 1'b0},
                  {32'h0002_000E, 1'b0}, {32'h0000_FFFF, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            run_op(c_l[i], a_l[i], b_l[i], hi, lo, dz, lat);
            checks++;
            if (lat !== 17) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges, want 17", i, lat);
            end
            checks++;
            if ({hi, lo, dz} !== exp_l[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got hi=%h lo=%h dbz=%b, want %h", i, hi, lo, dz, exp_l[i]);
            end
        end
        // done is a single-cycle pulse and the results hold afterwards
        @(posedge clk); #1;
        checks++;
        if ({done, busy, result_hi, result_lo} !== {2'b00, 32'h0000_FFFF}) begin
            errors++;
            $display("FAIL done_pulse_hold: got done=%b busy=%b hi=%h lo=%h, want 0 0 0000 ffff",
                     done, busy, result_hi, result_lo);
        end
    endtask

    task automatic test_div_by_zero;
        logic [15:0] hi, lo;
        logic        dz;
        int          lat;
        run_op(1'b1, 16'h1234, 16'h0, hi, lo, dz, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d edges, want 1", lat);
        end
        checks++;
        if ({hi, lo, dz} !== {16'h1234, 16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b, want 1234 ffff 1", hi, lo, dz);
        end
        // The next accepted start clears the flag while the old results hold
        @(negedge clk);
        start = 1'b1; cmd = 1'b0; opa = 16'd7; opb = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, div_by_zero, result_hi, result_lo} !== {2'b10, 16'h1234, 16'hFFFF}) begin
            errors++;
            $display("FAIL dbz_clear: got busy=%b dbz=%b hi=%h lo=%h, want 1 0 1234 ffff",
                     busy, div_by_zero, result_hi, result_lo);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== {16'h0, 16'd7, 5'b00001}) begin
            errors++;
            $display("FAIL run_alu_drive: got a=%h b=%h op=%b, want 0000 0007 00001", alu_a, alu_b, alu_op);
        end
        wait_done(lat);
        checks++;
        if (lat !== 17 || {result_hi, result_lo, div_by_zero} !== {32'd63, 1'b0}) begin
            errors++;
            $display("FAIL post_dbz_mul: got lat=%0d hi=%h lo=%h dbz=%b, want 17 0000 003f 0",
                     lat, result_hi, result_lo, div_by_zero);
        end
    endtask

    task automatic test_start_during_run;
        int lat;
        @(negedge clk);
        start = 1'b1; cmd = 1'b0; opa = 16'd3; opb = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            start = (k >= 3 && k <= 6);
            cmd = 1'b1; opa = 16'd999; opb = 16'd4;
        end
        start = 1'b0;
        checks++;
        if (lat !== 17 || {result_hi, result_lo, div_by_zero} !== {32'h0000_000F, 1'b0}) begin
            errors++;
            $display("FAIL start_in_run: got lat=%0d hi=%h lo=%h dbz=%b, want 17 0000 000f 0",
                     lat, result_hi, result_lo, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start = 1'b1; cmd = 1'b0; opa = 16'hFFFF; opb = 16'hFFFF;
        @(posedge clk); #1;
        cmd = 1'b1; opa = 16'd100; opb = 16'd7;   // start stays high
        wait_done(lat);
        checks++;
        if (lat !== 17 || {result_hi, result_lo} !== 32'hFFFE_0001) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h, want 17 fffe 0001", lat, result_hi, result_lo);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_no_idle: got busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(lat);
        checks++;
        if (lat !== 17 || {result_hi, result_lo} !== 32'h0002_000E) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h, want 17 0002 000e", lat, result_hi, result_lo);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] hi, lo;
        logic        dz;
        int          lat;
        int          seen_done;
        @(negedge clk);
        start = 1'b1; cmd = 1'b0; opa = 16'h1234; opb = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        seen_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (seen_done != 0 || {busy, done, div_by_zero, result_hi, result_lo} !== 35'h0 ||
            {alu_a, alu_b, alu_op} !== {32'h0, 5'b00001}) begin
            errors++;
            $display("FAIL reset_mid_run: got early_done=%0d busy=%b done=%b dbz=%b hi=%h lo=%h a=%h b=%h op=%b, want all reset",
                     seen_done, busy, done, div_by_zero, result_hi, result_lo, alu_a, alu_b, alu_op);
        end
        // start while in reset is ignored
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL start_in_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        run_op(1'b0, 16'd3, 16'd5, hi, lo, dz, lat);
        checks++;
        if (lat !== 17 || {hi, lo, dz} !== {32'h0000_000F, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_mul: got lat=%0d hi=%h lo=%h dbz=%b, want 17 0000 000f 0", lat, hi, lo, dz);
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b, hi, lo;
        logic        c, dz;
        int          lat;
        logic [32:0] exp_v;
        for (int i = 0; i < 30; i++) begin
            c = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if (i % 5 == 0) b = 16'($urandom_range(1, 15));
            exp_v = model(c, a, b);
            run_op(c, a, b, hi, lo, dz, lat);
            checks++;
            if ({hi, lo, dz} !== exp_v || lat !== ((c && b == 16'h0) ? 1 : 17)) begin
                errors++;
                $display("FAIL random[%0d] cmd=%b a=%h b=%h: got hi=%h lo=%h dbz=%b lat=%0d, want %h",
                         i, c, a, b, hi, lo, dz, lat, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        cmd    = 1'b0;
        opa    = 16'h0;
        opb    = 16'h0;
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_directed;
        test_div_by_zero;
        test_start_during_run;
        test_back_to_back;
        test_reset_mid_run;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
